// File: rtl/legv8_isa_pkg.sv
// ---------------------------------------------------------------------------
// legv8_isa_pkg
// Shared LEGv8 ISA definitions used by both the control-unit decode and the
// instruction encoder: the descriptor operation enumeration, the instruction
// format classes, the fixed opcode field values and the field widths.
//
// Helper functions:
//   opFormat(op) : which instruction format an operation code packs into
//   opcodeOf(op) : the fixed opcode field, right-aligned in 11 bits
// ---------------------------------------------------------------------------
package legv8_isa_pkg;

    localparam int OP_W     = 5;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 26;
    localparam int INSTR_W  = 32;

    localparam int R_OPC_W  = 11;
    localparam int I_OPC_W  = 10;
    localparam int D_OPC_W  = 11;
    localparam int IM_OPC_W = 9;
    localparam int B_OPC_W  = 6;
    localparam int CB_OPC_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_AND   = 5'd2,  OP_ORR   = 5'd3,
        OP_EOR   = 5'd4,  OP_ADDS  = 5'd5,  OP_SUBS  = 5'd6,  OP_ANDS  = 5'd7,
        OP_ADDI  = 5'd8,  OP_SUBI  = 5'd9,  OP_ANDI  = 5'd10, OP_ORRI  = 5'd11,
        OP_EORI  = 5'd12, OP_ADDIS = 5'd13, OP_SUBIS = 5'd14, OP_ANDIS = 5'd15,
        OP_LDUR  = 5'd16, OP_STUR  = 5'd17, OP_MOVZ  = 5'd18, OP_MOVK  = 5'd19,
        OP_B     = 5'd20, OP_BL    = 5'd21, OP_CBZ   = 5'd22, OP_CBNZ  = 5'd23,
        OP_BCOND = 5'd24, OP_BR    = 5'd25
    } op_e;

    typedef enum logic [3:0] {
        FMT_R, FMT_I, FMT_D, FMT_IM, FMT_B, FMT_CB, FMT_BCOND, FMT_BR, FMT_ILLEGAL
    } fmt_e;

    // BR has no variable fields except Rn, so it is kept as a full word
    localparam logic [INSTR_W-1:0] OPC_BR_BASE = 32'hD61F_0000;

    // The op codes are grouped by format, so ranges select the format
    function automatic fmt_e opFormat(input logic [OP_W-1:0] op);
        if (op <= OP_ANDS)       return FMT_R;
        else if (op <= OP_ANDIS) return FMT_I;
        else if (op <= OP_STUR)  return FMT_D;
        else if (op <= OP_MOVK)  return FMT_IM;
        else if (op <= OP_BL)    return FMT_B;
        else if (op <= OP_CBNZ)  return FMT_CB;
        else if (op == OP_BCOND) return FMT_BCOND;
        else if (op == OP_BR)    return FMT_BR;
        else                     return FMT_ILLEGAL;
    endfunction

    // Narrower opcodes are zero-extended; each format slices its own width
    function automatic logic [10:0] opcodeOf(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD:   return 11'h458;
            OP_SUB:   return 11'h658;
            OP_AND:   return 11'h450;
            OP_ORR:   return 11'h550;
            OP_EOR:   return 11'h650;
            OP_ADDS:  return 11'h558;
            OP_SUBS:  return 11'h758;
            OP_ANDS:  return 11'h750;
            OP_ADDI:  return 11'h244;
            OP_SUBI:  return 11'h344;
            OP_ANDI:  return 11'h248;
            OP_ORRI:  return 11'h2C8;
            OP_EORI:  return 11'h348;
            OP_ADDIS: return 11'h2C4;
            OP_SUBIS: return 11'h3C4;
            OP_ANDIS: return 11'h3C8;
            OP_LDUR:  return 11'h7C2;
            OP_STUR:  return 11'h7C0;
            OP_MOVZ:  return 11'h1A5;
            OP_MOVK:  return 11'h1E5;
            OP_B:     return 11'h005;
            OP_BL:    return 11'h025;
            OP_CBZ:   return 11'h0B4;
            OP_CBNZ:  return 11'h0B5;
            OP_BCOND: return 11'h054;
            default:  return 11'h000;
        endcase
    endfunction

endpackage

// File: rtl/legv8_encode_fields.sv
// ---------------------------------------------------------------------------
// legv8_encode_fields
// Combinational field packer and range checker for one instruction
// descriptor. Produces the 32-bit LEGv8 word and a flag saying whether the
// operation is defined and its immediate fits the target field.
//
// Ports:
//   op    in  5   operation code (legv8_isa_pkg::op_e values, 26-31 illegal)
//   rd    in  5   Rd / Rt; {0,cond} for B.cond
//   rn    in  5   Rn
//   rm    in  5   Rm
//   imm   in  26  raw immediate; shamt in [5:0] for R ops, hw in [17:16]
//   word  out 32  packed instruction (zero when not legal)
//   legal out 1   op defined and immediate in range
// ---------------------------------------------------------------------------
module legv8_encode_fields
    import legv8_isa_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [REG_W-1:0]   rd,
    input  logic [REG_W-1:0]   rn,
    input  logic [REG_W-1:0]   rm,
    input  logic [IMM_W-1:0]   imm,
    output logic [INSTR_W-1:0] word,
    output logic               legal
);

    logic [10:0] w_opc;
    fmt_e        w_fmt;
    logic        w_dFits;
    logic        w_cbFits;

    assign w_opc = opcodeOf(op);
    assign w_fmt = opFormat(op);

    // Signed offsets fit when every bit above the field's sign bit copies it
    assign w_dFits  = (imm[25:8]  == {18{imm[8]}});
    assign w_cbFits = (imm[25:18] == {8{imm[18]}});

    // Pack the fields of the selected format; anything unrecognised stays
    // zero and not legal
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (w_fmt)
            FMT_R: begin
                word  = {w_opc[R_OPC_W-1:0], rm, imm[5:0], rn, rd};
                legal = ~|imm[25:6];
            end
            FMT_I: begin
                word  = {w_opc[I_OPC_W-1:0], imm[11:0], rn, rd};
                legal = ~|imm[25:12];
            end
            FMT_D: begin
                word  = {w_opc[D_OPC_W-1:0], imm[8:0], 2'b00, rn, rd};
                legal = w_dFits;
            end
            FMT_IM: begin
                word  = {w_opc[IM_OPC_W-1:0], imm[17:16], imm[15:0], rd};
                legal = ~|imm[25:18];
            end
            FMT_B: begin
                word  = {w_opc[B_OPC_W-1:0], imm};
                legal = 1'b1;
            end
            FMT_CB: begin
                word  = {w_opc[CB_OPC_W-1:0], imm[18:0], rd};
                legal = w_cbFits;
            end
            FMT_BCOND: begin
                word  = {w_opc[CB_OPC_W-1:0], imm[18:0], 1'b0, rd[3:0]};
                legal = w_cbFits;
            end
            FMT_BR: begin
                word  = OPC_BR_BASE | {22'd0, rn, 5'd0};
                legal = 1'b1;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// ---------------------------------------------------------------------------
// legv8_instr_encoder
// Streams instruction descriptors into encoded LEGv8 words, each tagged with
// its byte address. One-cycle latency, one word per cycle through a single
// output register with valid/ready flow control. Illegal or out-of-range
// descriptors are consumed without output and latch a sticky error.
//
// Parameters: ADDR_W (address counter width), BASE_ADDR (start address)
// Ports:
//   clock, reset (sync, active-low), clear (soft clear of addr/count/err)
//   in_valid/in_ready, in_op, in_rd, in_rn, in_rm, in_imm : descriptor input
//   out_valid/out_ready, out_instr, out_addr              : word output
//   err (sticky), err_op (first failing op), count (saturating word count)
// ---------------------------------------------------------------------------
module legv8_instr_encoder
    import legv8_isa_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [REG_W-1:0]   in_rn,
    input  logic [REG_W-1:0]   in_rm,
    input  logic [IMM_W-1:0]   in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               err,
    output logic [OP_W-1:0]    err_op,
    output logic [15:0]        count
);

    logic [INSTR_W-1:0] w_word;
    logic               w_legal;
    logic               w_accept;
    logic               w_xfer;

    logic               r_outValid;
    logic [INSTR_W-1:0] r_outInstr;
    logic [ADDR_W-1:0]  r_outAddr;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_count;
    logic               r_err;
    logic [OP_W-1:0]    r_errOp;

    legv8_encode_fields u_fields (
        .op    (in_op),
        .rd    (in_rd),
        .rn    (in_rn),
        .rm    (in_rm),
        .imm   (in_imm),
        .word  (w_word),
        .legal (w_legal)
    );

    assign in_ready  = ~r_outValid | out_ready;
    assign w_accept  = in_valid & in_ready;
    assign w_xfer    = r_outValid & out_ready;

    assign out_valid = r_outValid;
    assign out_instr = r_outInstr;
    assign out_addr  = r_outAddr;
    assign err       = r_err;
    assign err_op    = r_errOp;
    assign count     = r_count;

    // Output register: a legal accepted word loads it, otherwise a completed
    // transfer empties it. Clear is deliberately ignored here so a pending
    // word still finishes its handshake.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_outValid <= 1'b0;
            r_outInstr <= '0;
            r_outAddr  <= BASE_ADDR;
        end else if (w_accept && w_legal) begin
            r_outValid <= 1'b1;
            r_outInstr <= w_word;
            r_outAddr  <= r_addr;
        end else if (w_xfer) begin
            r_outValid <= 1'b0;
        end
    end

    // Byte address of the next legal word; wraps naturally at ADDR_W bits
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            r_addr <= BASE_ADDR;
        end else if (w_accept && w_legal) begin
            r_addr <= r_addr + ADDR_W'(4);
        end
    end

    // Words actually handed downstream, held at all-ones once saturated
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            r_count <= '0;
        end else if (w_xfer && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Only the first bad descriptor is recorded; clear re-arms the capture
    // but leaves the last recorded op visible
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err   <= 1'b0;
            r_errOp <= '0;
        end else if (clear) begin
            r_err   <= 1'b0;
        end else if (w_accept && !w_legal && !r_err) begin
            r_err   <= 1'b1;
            r_errOp <= in_op;
        end
    end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_legv8_instr_encoder
// Drives two encoders (16-bit and 4-bit address counters) with the same
// descriptor stream. Expected words come from an arithmetic model of the
// instruction formats and are queued at acceptance; a monitor pops them as
// words leave the DUT.
// ---------------------------------------------------------------------------
module tb_legv8_instr_encoder;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] addr;
    } exp_t;

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        clear     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [4:0]  in_op     = '0;
    logic [4:0]  in_rd     = '0;
    logic [4:0]  in_rn     = '0;
    logic [4:0]  in_rm     = '0;
    logic [25:0] in_imm    = '0;

    logic        in_readyA, out_validA, errA;
    logic [31:0] out_instrA;
    logic [15:0] out_addrA, countA;
    logic [4:0]  err_opA;

    logic        in_readyB, out_validB, errB;
    logic [31:0] out_instrB;
    logic [3:0]  out_addrB;
    logic [15:0] countB;
    logic [4:0]  err_opB;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   expAddr = 0;
    int   expCount = 0;
    bit   expErr = 0;
    int   expErrOp = 0;
    int   readyMode = 0;
    int   stallCycles = 0;

    int rOpcTab[8] = '{'h458, 'h658, 'h450, 'h550, 'h650, 'h558, 'h758, 'h750};
    int iOpcTab[8] = '{'h244, 'h344, 'h248, 'h2C8, 'h348, 'h2C4, 'h3C4, 'h3C8};

    legv8_instr_encoder #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dutA (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_readyA), .in_op(in_op),
        .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .out_valid(out_validA), .out_ready(out_ready), .out_instr(out_instrA),
        .out_addr(out_addrA), .err(errA), .err_op(err_opA), .count(countA)
    );

    legv8_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dutB (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_readyB), .in_op(in_op),
        .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
        .out_valid(out_validB), .out_ready(out_ready), .out_instr(out_instrB),
        .out_addr(out_addrB), .err(errB), .err_op(err_opB), .count(countB)
    );

    always #5 clock = ~clock;

    // Reference encoder: builds each word by weighting fields with powers of
    // two and judges range on the signed / unsigned value of the immediate
    function automatic void refEncode(input int op, input int rd, input int rn, input int rm,
                                      input logic [25:0] immBits,
                                      output logic [31:0] word, output bit ok);
        longint imm, s, acc, fld, opc;
        imm = longint'(immBits);
        s   = (imm >= 33554432) ? imm - 67108864 : imm;
        acc = 0;
        ok  = 0;
        if (op < 8) begin
            ok  = (imm < 64);
            opc = longint'(rOpcTab[op]);
            acc = opc * 2097152 + rm * 65536 + imm * 1024 + rn * 32 + rd;
        end else if (op < 16) begin
            ok  = (imm < 4096);
            opc = longint'(iOpcTab[op-8]);
            acc = opc * 4194304 + imm * 1024 + rn * 32 + rd;
        end else if (op < 18) begin
            ok  = (s >= -256) && (s <= 255);
            fld = (s + 512) % 512;
            opc = (op == 16) ? 'h7C2 : 'h7C0;
            acc = opc * 2097152 + fld * 4096 + rn * 32 + rd;
        end else if (op < 20) begin
            ok  = (imm < 262144);
            opc = (op == 18) ? 'h1A5 : 'h1E5;
            acc = opc * 8388608 + (imm / 65536) * 2097152 + (imm % 65536) * 32 + rd;
        end else if (op < 22) begin
            ok  = 1;
            opc = (op == 20) ? 5 : 37;
            acc = opc * 67108864 + imm;
        end else if (op < 25) begin
            ok  = (s >= -262144) && (s <= 262143);
            fld = (s + 524288) % 524288;
            opc = (op == 22) ? 'hB4 : ((op == 23) ? 'hB5 : 'h54);
            acc = opc * 16777216 + fld * 32 + ((op == 24) ? (rd % 16) : rd);
        end else if (op == 25) begin
            ok  = 1;
            opc = longint'(32'hD61F0000);
            acc = opc + rn * 32;
        end
        word = acc[31:0];
    endfunction

    function automatic logic [25:0] randImm();
        int v;
        case ($urandom % 5)
            0: return 26'($urandom);
            1: return 26'($urandom % 4096);
            2: begin
                v = int'($urandom % 600) - 300;
                return 26'(v);
            end
            3: return 26'($urandom % 262144);
            default: return 26'($urandom % 64);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Offer one descriptor until accepted, then record what the DUT owes us
    task automatic applyStimulus(input int op, input int rd, input int rn, input int rm,
                                 input logic [25:0] imm, input bit useLit,
                                 input logic [31:0] litWord, input bit litOk);
        logic [31:0] w;
        bit ok;
        bit acc;
        exp_t e;
        acc = 0;
        if (useLit) begin
            w  = litWord;
            ok = litOk;
        end else begin
            refEncode(op, rd, rn, rm, imm, w, ok);
        end
        @(negedge clock);
        in_op    = 5'(op);
        in_rd    = 5'(rd);
        in_rn    = 5'(rn);
        in_rm    = 5'(rm);
        in_imm   = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (in_readyA) begin
                acc = 1;
                break;
            end
            @(negedge clock);
        end
        if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clock);
            if (ok) begin
                e.instr = w;
                e.addr  = 16'(expAddr);
                expQ.push_back(e);
                expAddr = (expAddr + 4) % 65536;
            end else if (!expErr) begin
                expErr   = 1;
                expErrOp = op;
            end
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        expQ.delete();
        expAddr  = 0;
        expCount = 0;
        expErr   = 0;
        expErrOp = 0;
    endtask

    task automatic drainOutputs();
        bit done;
        done = 0;
        readyMode   = 0;
        stallCycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            #3;
            if (expQ.size() == 0 && !out_validA) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: %0d words outstanding, expected 0", expQ.size());
        end
        @(negedge clock);
        #3;
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_err"},      32'(errA),    32'(expErr));
        checkOutput({tag, "_err_op"},   32'(err_opA), 32'(expErrOp));
        checkOutput({tag, "_count"},    32'(countA),  32'(expCount));
        checkOutput({tag, "_errB"},     32'(errB),    32'(expErr));
        checkOutput({tag, "_err_opB"},  32'(err_opB), 32'(expErrOp));
        checkOutput({tag, "_countB"},   32'(countB),  32'(expCount));
        checkOutput({tag, "_in_readyB"}, 32'(in_readyB), 32'd1);
    endtask

    // Downstream readiness: forced stalls first, then the selected mode
    initial begin
        forever begin
            @(negedge clock);
            if (stallCycles > 0) begin
                out_ready = 1'b0;
                stallCycles--;
            end else begin
                case (readyMode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (($urandom % 4) != 0);
                    default: out_ready = 1'b0;
                endcase
            end
        end
    end

    // Monitor: a word presented with out_ready high transfers at the next
    // rising edge and is popped against the queue; a stalled word must be
    // unchanged on the following cycle
    initial begin
        bit          prevStall;
        logic [31:0] heldInstr;
        logic [15:0] heldAddr;
        exp_t        e;
        prevStall = 0;
        heldInstr = '0;
        heldAddr  = '0;
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                prevStall = 0;
            end else begin
                if (prevStall) begin
                    checkOutput("stall_valid", 32'(out_validA), 32'd1);
                    checkOutput("stall_instr", out_instrA, heldInstr);
                    checkOutput("stall_addr",  32'(out_addrA), 32'(heldAddr));
                end
                prevStall = 0;
                if (out_validA && !out_ready) begin
                    prevStall = 1;
                    heldInstr = out_instrA;
                    heldAddr  = out_addrA;
                end else if (out_validA && out_ready) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_word: got 0x%08h, expected no word", out_instrA);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("instr",  out_instrA, e.instr);
                        checkOutput("addr",   32'(out_addrA), 32'(e.addr));
                        checkOutput("validB", 32'(out_validB), 32'd1);
                        checkOutput("instrB", out_instrB, e.instr);
                        checkOutput("addrB",  32'(out_addrB), 32'(e.addr[3:0]));
                        expCount++;
                    end
                end
            end
        end
    end

    initial begin
        int op;
        $display("[TB] start");

        // Reset state
        doReset();
        #3;
        checkOutput("rst_out_valid", 32'(out_validA), 32'd0);
        checkOutput("rst_out_instr", out_instrA, 32'd0);
        checkOutput("rst_out_addr",  32'(out_addrA), 32'd0);
        checkOutput("rst_count",     32'(countA), 32'd0);
        checkOutput("rst_err",       32'(errA), 32'd0);
        checkOutput("rst_err_op",    32'(err_opA), 32'd0);
        checkOutput("rst_in_ready",  32'(in_readyA), 32'd1);

        // Known encodings
        applyStimulus(0, 1, 2, 3, 26'h0, 1, 32'h8B030041, 1);
        applyStimulus(8, 9, 9, 0, 26'hFFF, 1, 32'h913FFD29, 1);
        applyStimulus(8, 9, 9, 0, 26'h1000, 1, 32'h0, 0);
        drainOutputs();
        checkOutput("addi_err",    32'(errA), 32'd1);
        checkOutput("addi_err_op", 32'(err_opA), 32'd8);
        applyStimulus(1, 4, 5, 6, 26'h0, 0, 32'h0, 0);
        applyStimulus(16, 5, 6, 0, 26'h3FFFFF8, 1, 32'hF85F80C5, 1);
        applyStimulus(16, 5, 6, 0, 26'h100, 1, 32'h0, 0);
        applyStimulus(23, 0, 0, 0, 26'h3FFFFFF, 1, 32'hB5FFFFE0, 1);
        applyStimulus(24, 1, 0, 0, 26'h2, 1, 32'h54000041, 1);
        drainOutputs();
        checkStatus("directed");

        // Four words with a three-cycle stall in the middle
        doReset();
        applyStimulus(18, 3, 0, 0, 26'h2ABCD, 0, 32'h0, 0);
        applyStimulus(19, 4, 0, 0, 26'h11234, 0, 32'h0, 0);
        stallCycles = 3;
        applyStimulus(20, 0, 0, 0, 26'h3FFFFFF, 0, 32'h0, 0);
        applyStimulus(25, 0, 30, 0, 26'h0, 0, 32'h0, 0);
        drainOutputs();
        checkOutput("stream_count", 32'(countA), 32'd4);
        checkStatus("stream");

        // Address wrap on the 4-bit instance, then clear during a stall
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(2, i, i + 1, i + 2, 26'(i), 0, 32'h0, 0);
        drainOutputs();
        applyStimulus(27, 0, 0, 0, 26'h0, 0, 32'h0, 0);
        drainOutputs();
        checkOutput("pre_clear_err", 32'(errA), 32'd1);
        readyMode = 2;
        applyStimulus(21, 0, 0, 0, 26'h155, 0, 32'h0, 0);
        @(negedge clock);
        clear    = 1'b1;
        expAddr  = 0;
        expErr   = 0;
        expCount = 0;
        @(negedge clock);
        clear = 1'b0;
        #3;
        checkOutput("clear_err",   32'(errA), 32'd0);
        checkOutput("clear_count", 32'(countA), 32'd0);
        checkOutput("clear_held",  32'(out_validA), 32'd1);
        readyMode = 0;
        applyStimulus(11, 7, 8, 0, 26'h0F0, 0, 32'h0, 0);
        drainOutputs();
        checkStatus("clear");

        // Reset while a word is waiting discards it
        readyMode = 2;
        applyStimulus(9, 1, 1, 0, 26'h10, 0, 32'h0, 0);
        @(negedge clock);
        #3;
        checkOutput("pend_valid", 32'(out_validA), 32'd1);
        doReset();
        readyMode = 0;
        #3;
        checkOutput("rst_drop_valid", 32'(out_validA), 32'd0);
        checkOutput("rst_drop_addr",  32'(out_addrA), 32'd0);

        // Randomised traffic with random back-pressure
        readyMode = 1;
        for (int n = 0; n < 400; n++) begin
            if (($urandom % 4) == 0) repeat ($urandom % 3) @(negedge clock);
            if (($urandom % 25) == 0) stallCycles = int'($urandom_range(1, 4));
            op = int'($urandom % 32);
            applyStimulus(op, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
                          randImm(), 0, 32'h0, 0);
        end
        drainOutputs();
        checkStatus("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
